sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Shares the single Blackice-II sram core command port between two requesters, m0 and m1; a typical pairing is the AXI bridge and a video/DMA engine. Grants are round-robin and the winning command is registered onto the sram control signals. Each accepted read is tagged in an in-order FIFO so that returned read data is routed to the requester that issued it.

Parameters:
ADDR_WIDTH, 18, sram word address width
DATA_WIDTH, 16, sram data width
TAG_DEPTH, 4, maximum outstanding reads; power of two, at least 2

Ports:
a_clk  in  1  clock; all logic on the rising edge
a_rst  in  1  reset, synchronous, active-high
mN_req  in  1  requester N command valid (N = 0, 1; all mN_* ports exist per requester)
mN_ready  out  1  requester N command accepted this cycle
mN_rd  in  1  1 = read, 0 = write
mN_addr  in  ADDR_WIDTH  word address
mN_be  in  2  byte enables, passed through unchanged
mN_wr_data  in  DATA_WIDTH  write data
mN_rd_data_vld  out  1  read data for requester N is valid this cycle
mN_rd_data  out  DATA_WIDTH  read data; driven to both requesters
sram_req  out  1  command valid to the sram core
sram_ready  in  1  sram core accepts the command this cycle
sram_rd  out  1  registered command type
sram_addr  out  ADDR_WIDTH  registered address
sram_be  out  2  registered byte enables
sram_wr_data  out  DATA_WIDTH  registered write data
sram_rd_data_vld  in  1  read data valid from the core
sram_rd_data  in  DATA_WIDTH  read data from the core
err_orphan  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (a_rst = 1 at a clock edge):
  - sram_req, sram_rd, sram_addr, sram_be, sram_wr_data, err_orphan all go to 0.
  - State goes to IDLE, priority pointer to m0, tag FIFO is emptied.
  - Reset mid-transaction drops the held command without a handshake.
  - Read data for reads in flight before reset lands on an empty FIFO, so it sets err_orphan.
- Requester protocol: once mN_req is asserted, mN_req, mN_rd, mN_addr, mN_be and mN_wr_data hold until the cycle mN_ready = 1.
- Eligibility: requester N is eligible when mN_req = 1 and not (mN_rd = 1 and tag FIFO full).
- State IDLE:
  - No eligible requester: stay in IDLE.
  - One eligible requester: grant it.
  - Both eligible: grant the requester the pointer names.
  - On a grant, register the winner's rd/addr/be/wr_data onto the sram_* outputs, set sram_req = 1, store the grant id, go to BUSY.
  - The pointer then moves to the other requester.
- State BUSY:
  - sram_* outputs hold stable while sram_ready = 0.
  - mN_ready = sram_req & sram_ready & (grant == N); this is combinational, a one-cycle pulse.
  - On sram_ready: sram_req goes to 0 next edge and the state returns to IDLE.
  - If sram_rd = 1, push the grant id into the tag FIFO in the same edge.
- Throughput: minimum 2 cycles per command (grant edge, then accept, then back to IDLE). sram_req is never high in two consecutive accept cycles.
- Read return:
  - mN_rd_data_vld = sram_rd_data_vld & !fifo_empty & (fifo_head == N).
  - mN_rd_data = sram_rd_data, no added latency.
  - Pop the FIFO on sram_rd_data_vld when it is not empty.
- Simultaneous push and pop: allowed, including when the FIFO is full; count stays unchanged.
- Full FIFO:
  - Read requests are not eligible; writes still are.
  - A granted command is never retracted.
- Empty FIFO with sram_rd_data_vld: err_orphan is set and stays set until reset; no mN_rd_data_vld is asserted.
- Pointers and count: FIFO pointers wrap modulo TAG_DEPTH; the count has width log2(TAG_DEPTH)+1.

Test Plan:
- Single requester: m0 write addr 0x00010, be 2'b00, data 0xBEEF; sram_ready asserted 1 cycle after sram_req.
  - Required: sram_req high for exactly 2 cycles with sram_addr = 0x00010, sram_wr_data = 0xBEEF.
  - m0_ready pulses once, m1_ready stays 0.
- Contention: m0 and m1 both hold read requests; the core accepts every command immediately.
  - Required: grants go m0, m1, m0, m1.
  - Read data 0x1111, 0x2222, 0x3333, 0x4444 is returned 4 cycles after each accept and reaches m0, m1, m0, m1 on mN_rd_data_vld.
- FIFO full: 4 reads from m0 accepted with no data returned yet; m0 then requests a read and m1 requests a write.
  - Required: m1's write is granted, m0's read is not.
  - After one sram_rd_data_vld, m0's read is granted.
- Stall: sram_ready is held 0 for 5 cycles after sram_req goes high, while m1_req toggles its fields.
  - Required: sram_* outputs stay constant.
  - No mN_ready until sram_ready = 1.
- Orphan: sram_rd_data_vld is pulsed with the FIFO empty.
  - Required: err_orphan = 1 from the next cycle onward, both mN_rd_data_vld stay 0.
  - err_orphan clears only on a_rst.
- Mid-op reset: a_rst is asserted for 1 cycle while in BUSY with 2 reads outstanding.
  - Required: sram_req = 0 and FIFO empty next cycle, pointer back to m0.
  - The next contention grants m0 first.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of the sram core command port.
// The winning command is registered onto the sram_* outputs, and every accepted
// read leaves a requester tag in an in-order FIFO. Returned read data is routed
// to whichever requester owns the tag at the head of that FIFO.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic                  m0_req,
    output logic                  m0_ready,
    input  logic                  m0_rd,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [1:0]            m0_be,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic                  m0_rd_data_vld,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    input  logic                  m1_req,
    output logic                  m1_ready,
    input  logic                  m1_rd,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [1:0]            m1_be,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic                  m1_rd_data_vld,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  sram_req,
    input  logic                  sram_ready,
    output logic                  sram_rd,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [1:0]            sram_be,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    input  logic                  sram_rd_data_vld,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    output logic                  err_orphan
);
    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_reg, state_next;
    logic                  ptr_reg, ptr_next;      // requester that wins a tie
    logic                  grant_reg, grant_next;  // owner of the held command
    logic                  cmd_load;
    logic                  win;

    logic                  sram_req_reg;
    logic                  sram_rd_reg;
    logic [ADDR_WIDTH-1:0] sram_addr_reg;
    logic [1:0]            sram_be_reg;
    logic [DATA_WIDTH-1:0] sram_wr_data_reg;
    logic                  err_orphan_reg;

    // Tag FIFO: one bit per entry holds the requester id of an accepted read.
    logic [TAG_DEPTH-1:0]  tag_reg;
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]           count_reg;
    logic                  fifo_full, fifo_empty, fifo_head;
    logic                  push, pop;

    logic [1:0]            req_vec, rd_vec, elig_vec, ready_vec, vld_vec;

    assign req_vec    = {m1_req, m0_req};
    assign rd_vec     = {m1_rd, m0_rd};
    assign fifo_full  = (count_reg == (PW+1)'(TAG_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign fifo_head  = tag_reg[rd_ptr_reg];
    assign push       = sram_req_reg & sram_ready & sram_rd_reg;
    assign pop        = sram_rd_data_vld & ~fifo_empty;

    // Per-requester eligibility, accept strobe and read-data routing.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign elig_vec[gi]  = req_vec[gi] & ~(rd_vec[gi] & fifo_full);
            assign ready_vec[gi] = sram_req_reg & sram_ready & (grant_reg == 1'(gi));
            assign vld_vec[gi]   = sram_rd_data_vld & ~fifo_empty & (fifo_head == 1'(gi));
        end
    endgenerate

    assign m0_ready       = ready_vec[0];
    assign m1_ready       = ready_vec[1];
    assign m0_rd_data_vld = vld_vec[0];
    assign m1_rd_data_vld = vld_vec[1];
    assign m0_rd_data     = sram_rd_data;
    assign m1_rd_data     = sram_rd_data;
    assign sram_req       = sram_req_reg;
    assign sram_rd        = sram_rd_reg;
    assign sram_addr      = sram_addr_reg;
    assign sram_be        = sram_be_reg;
    assign sram_wr_data   = sram_wr_data_reg;
    assign err_orphan     = err_orphan_reg;

    // Next state: pick a winner in IDLE, wait for the core's accept in BUSY.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        cmd_load   = 1'b0;
        win        = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (elig_vec != 2'b00) begin
                    win        = (elig_vec == 2'b11) ? ptr_reg : elig_vec[1];
                    grant_next = win;
                    ptr_next   = ~win;
                    cmd_load   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (sram_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration pointer and the registered sram command.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_reg        <= IDLE;
            ptr_reg          <= 1'b0;
            grant_reg        <= 1'b0;
            sram_req_reg     <= 1'b0;
            sram_rd_reg      <= 1'b0;
            sram_addr_reg    <= '0;
            sram_be_reg      <= '0;
            sram_wr_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            if (cmd_load) begin
                sram_req_reg     <= 1'b1;
                sram_rd_reg      <= win ? m1_rd      : m0_rd;
                sram_addr_reg    <= win ? m1_addr    : m0_addr;
                sram_be_reg      <= win ? m1_be      : m0_be;
                sram_wr_data_reg <= win ? m1_wr_data : m0_wr_data;
            end else if (sram_req_reg && sram_ready) begin
                sram_req_reg <= 1'b0;
            end
        end
    end

    // Tag FIFO bookkeeping; push and pop may coincide, even when full.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Tag storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge a_clk) begin
        if (push) begin
            tag_reg[wr_ptr_reg] <= grant_reg;
        end
    end

    // Sticky flag for read data arriving with no outstanding tag.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            err_orphan_reg <= 1'b0;
        end else if (sram_rd_data_vld && fifo_empty) begin
            err_orphan_reg <= 1'b1;
        end
    end
endmodule
